// File: rtl/turf_udp_pkg.sv
`default_nettype none
// ==========================================================================
// turf_udp_pkg : UDP header field layout and default TURF port map
// Rev 1.0
// ==========================================================================
package turf_udp_pkg;

   localparam int unsigned c_hdr_ip_lsb   = 32;
   localparam int unsigned c_hdr_ip_w     = 32;
   localparam int unsigned c_hdr_port_lsb = 16;
   localparam int unsigned c_hdr_port_w   = 16;
   localparam int unsigned c_hdr_len_lsb  = 0;
   localparam int unsigned c_hdr_len_w    = 16;

   // Channel index width covers the full legal range of 1..8 channels.
   localparam int unsigned c_idx_w = 3;

   localparam logic [15:0] c_port_0 = 16'd21600;
   localparam logic [15:0] c_port_1 = 16'd21601;
   localparam logic [15:0] c_port_2 = 16'd21602;
   localparam logic [15:0] c_port_3 = 16'd21603;
   localparam logic [63:0] c_def_port_list = {c_port_3, c_port_2, c_port_1, c_port_0};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_DROP = 2'd3
   } demux_state_e;

endpackage
`default_nettype wire

// File: rtl/turf_udp_port_match.sv
`default_nettype none
// ==========================================================================
// turf_udp_port_match : priority compare of a UDP port against a port list
// Rev 1.0
// ==========================================================================
module turf_udp_port_match
   import turf_udp_pkg::*;
#(
   parameter int                      NUM_PORTS = 4,
   parameter logic [16*NUM_PORTS-1:0] PORT_LIST = c_def_port_list
) (
   input  logic [c_hdr_port_w-1:0] tdest_i,
   output logic                    match_o,
   output logic [c_idx_w-1:0]      idx_o
);

   // Scan from the top down so the lowest matching entry wins.
   always_comb begin
      match_o = 1'b0;
      idx_o   = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (PORT_LIST[16*i +: 16] == tdest_i) begin
            match_o = 1'b1;
            idx_o   = c_idx_w'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/turf_udp_port_demux.sv
`default_nettype none
// ==========================================================================
// turf_udp_port_demux : routes UDP packets to a channel by destination port
// Rev 1.0
// ==========================================================================
module turf_udp_port_demux
   import turf_udp_pkg::*;
#(
   parameter int                      NUM_PORTS = 4,
   parameter logic [16*NUM_PORTS-1:0] PORT_LIST = c_def_port_list
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [63:0]             s_udphdr_tdata,
   input  logic [15:0]             s_udphdr_tdest,
   input  logic                    s_udphdr_tvalid,
   output logic                    s_udphdr_tready,
   input  logic [63:0]             s_udpdata_tdata,
   input  logic [7:0]              s_udpdata_tkeep,
   input  logic                    s_udpdata_tlast,
   input  logic                    s_udpdata_tvalid,
   output logic                    s_udpdata_tready,
   output logic [NUM_PORTS*64-1:0] m_udphdr_tdata,
   output logic [NUM_PORTS-1:0]    m_udphdr_tvalid,
   input  logic [NUM_PORTS-1:0]    m_udphdr_tready,
   output logic [NUM_PORTS*64-1:0] m_udpdata_tdata,
   output logic [NUM_PORTS*8-1:0]  m_udpdata_tkeep,
   output logic [NUM_PORTS-1:0]    m_udpdata_tlast,
   output logic [NUM_PORTS-1:0]    m_udpdata_tvalid,
   input  logic [NUM_PORTS-1:0]    m_udpdata_tready,
   output logic [31:0]             drop_count
);

   demux_state_e         state_q;
   logic [63:0]          hdr_q;
   logic [c_idx_w-1:0]   idx_q;
   logic [31:0]          drop_cnt_q;
   logic [31:0]          drop_cnt_d;

   logic                 w_match_vld;
   logic [c_idx_w-1:0]   w_match_idx;
   logic [NUM_PORTS-1:0] w_sel;
   logic                 w_in_hdr;
   logic                 w_in_data;
   logic                 w_beat_acc;

   turf_udp_port_match #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_LIST (PORT_LIST)
   ) u_match (
      .tdest_i (s_udphdr_tdest),
      .match_o (w_match_vld),
      .idx_o   (w_match_idx)
   );

   // Handshakes are gated by rst so nothing is offered or taken in reset.
   assign w_in_hdr         = (state_q == ST_HDR)  && !rst;
   assign w_in_data        = (state_q == ST_DATA) && !rst;
   assign s_udphdr_tready  = (state_q == ST_IDLE) && !rst;
   assign s_udpdata_tready = ((state_q == ST_DROP) && !rst) ||
                             (w_in_data && |(m_udpdata_tready & w_sel));
   assign w_beat_acc       = s_udpdata_tvalid && s_udpdata_tready;
   assign drop_count       = drop_cnt_q;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ch
      assign w_sel[i]                   = (idx_q == c_idx_w'(i));
      assign m_udphdr_tdata[64*i +: 64] = hdr_q;
      assign m_udphdr_tvalid[i]         = w_sel[i] && w_in_hdr;
      assign m_udpdata_tdata[64*i +: 64] = s_udpdata_tdata;
      assign m_udpdata_tkeep[8*i +: 8]  = s_udpdata_tkeep;
      assign m_udpdata_tlast[i]         = s_udpdata_tlast;
      assign m_udpdata_tvalid[i]        = w_sel[i] && w_in_data && s_udpdata_tvalid;
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if ((state_q == ST_DROP) && w_beat_acc && s_udpdata_tlast && (drop_cnt_q != '1))
         drop_cnt_d = drop_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         hdr_q      <= '0;
         idx_q      <= '0;
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         case (state_q)
            ST_IDLE: begin
               if (s_udphdr_tvalid) begin
                  hdr_q   <= s_udphdr_tdata;
                  idx_q   <= w_match_idx;
                  state_q <= w_match_vld ? ST_HDR : ST_DROP;
               end
            end
            ST_HDR: begin
               if (|(m_udphdr_tready & w_sel))
                  state_q <= ST_DATA;
            end
            ST_DATA, ST_DROP: begin
               if (w_beat_acc && s_udpdata_tlast)
                  state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_turf_udp_port_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_turf_udp_port_demux : scoreboard bench for the UDP port demultiplexer
// Rev 1.0
// ==========================================================================
module tb_turf_udp_port_demux;
   import turf_udp_pkg::*;

   localparam int NUM_PORTS = 4;
   localparam int TMO       = 64;

   typedef struct { int ch; logic [63:0] data; } hdr_t;
   typedef struct { int ch; logic [63:0] data; logic [7:0] keep; logic last; } beat_t;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [63:0]             s_udphdr_tdata;
   logic [15:0]             s_udphdr_tdest;
   logic                    s_udphdr_tvalid;
   logic                    s_udphdr_tready;
   logic [63:0]             s_udpdata_tdata;
   logic [7:0]              s_udpdata_tkeep;
   logic                    s_udpdata_tlast;
   logic                    s_udpdata_tvalid;
   logic                    s_udpdata_tready;
   logic [NUM_PORTS*64-1:0] m_udphdr_tdata;
   logic [NUM_PORTS-1:0]    m_udphdr_tvalid;
   logic [NUM_PORTS-1:0]    m_udphdr_tready;
   logic [NUM_PORTS*64-1:0] m_udpdata_tdata;
   logic [NUM_PORTS*8-1:0]  m_udpdata_tkeep;
   logic [NUM_PORTS-1:0]    m_udpdata_tlast;
   logic [NUM_PORTS-1:0]    m_udpdata_tvalid;
   logic [NUM_PORTS-1:0]    m_udpdata_tready;
   logic [31:0]             drop_count;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   int cur_ch   = -1;
   int hdr_acc_cyc  = 0;
   int last_acc_cyc = 0;
   bit bp_en = 1'b0;
   logic [3:0] bp_pat = 4'b1001;
   int bp_idx = 0;

   hdr_t  hdr_sb[$];
   beat_t beat_sb[$];
   hdr_t  mon_h;
   beat_t mon_b;
   logic [NUM_PORTS-1:0] mon_mask;
   logic [NUM_PORTS-1:0] hv_hold;
   logic [63:0]          hd_hold [NUM_PORTS];

   turf_udp_port_demux #(.NUM_PORTS(NUM_PORTS)) dut (
      .clk              (clk),
      .rst              (rst),
      .s_udphdr_tdata   (s_udphdr_tdata),
      .s_udphdr_tdest   (s_udphdr_tdest),
      .s_udphdr_tvalid  (s_udphdr_tvalid),
      .s_udphdr_tready  (s_udphdr_tready),
      .s_udpdata_tdata  (s_udpdata_tdata),
      .s_udpdata_tkeep  (s_udpdata_tkeep),
      .s_udpdata_tlast  (s_udpdata_tlast),
      .s_udpdata_tvalid (s_udpdata_tvalid),
      .s_udpdata_tready (s_udpdata_tready),
      .m_udphdr_tdata   (m_udphdr_tdata),
      .m_udphdr_tvalid  (m_udphdr_tvalid),
      .m_udphdr_tready  (m_udphdr_tready),
      .m_udpdata_tdata  (m_udpdata_tdata),
      .m_udpdata_tkeep  (m_udpdata_tkeep),
      .m_udpdata_tlast  (m_udpdata_tlast),
      .m_udpdata_tvalid (m_udpdata_tvalid),
      .m_udpdata_tready (m_udpdata_tready),
      .drop_count       (drop_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] mk_hdr(input logic [31:0] ip, input logic [15:0] port,
                                          input logic [15:0] len);
      logic [63:0] h;
      h = '0;
      h[c_hdr_ip_lsb +: c_hdr_ip_w]     = ip;
      h[c_hdr_port_lsb +: c_hdr_port_w] = port;
      h[c_hdr_len_lsb +: c_hdr_len_w]   = len;
      return h;
   endfunction

   // Channel 0 readiness follows the 1,0,0,1 pattern while bp_en is set.
   initial begin
      m_udphdr_tready  = '1;
      m_udpdata_tready = '1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_en) begin
            m_udphdr_tready[0]  = bp_pat[bp_idx];
            m_udpdata_tready[0] = bp_pat[bp_idx];
            bp_idx = (bp_idx + 1) % 4;
         end else begin
            m_udphdr_tready  = '1;
            m_udpdata_tready = '1;
            bp_idx = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         hv_hold = '0;
      end else begin
         mon_mask = (cur_ch >= 0) ? (NUM_PORTS'(1) << cur_ch) : '0;
         if ((m_udphdr_tvalid | m_udpdata_tvalid) != '0)
            check_eq("idle_channels_quiet",
                     64'((m_udphdr_tvalid | m_udpdata_tvalid) & ~mon_mask), 64'd0);
         for (int c = 0; c < NUM_PORTS; c++) begin
            if (hv_hold[c]) begin
               check_eq("hdr_hold_valid", 64'(m_udphdr_tvalid[c]), 64'd1);
               check_eq("hdr_hold_data", m_udphdr_tdata[64*c +: 64], hd_hold[c]);
            end
            hv_hold[c] = m_udphdr_tvalid[c] & ~m_udphdr_tready[c];
            hd_hold[c] = m_udphdr_tdata[64*c +: 64];
            if (m_udphdr_tvalid[c] && m_udphdr_tready[c]) begin
               check_eq("hdr_sb_nonempty", 64'(hdr_sb.size() != 0), 64'd1);
               if (hdr_sb.size() != 0) begin
                  mon_h = hdr_sb.pop_front();
                  check_eq("hdr_channel", 64'(c), 64'(mon_h.ch));
                  check_eq("hdr_data", m_udphdr_tdata[64*c +: 64], mon_h.data);
               end
            end
            if (m_udpdata_tvalid[c])
               check_eq("data_ready_pass", 64'(s_udpdata_tready), 64'(m_udpdata_tready[c]));
            if (m_udpdata_tvalid[c] && m_udpdata_tready[c]) begin
               check_eq("beat_sb_nonempty", 64'(beat_sb.size() != 0), 64'd1);
               if (beat_sb.size() != 0) begin
                  mon_b = beat_sb.pop_front();
                  check_eq("beat_channel", 64'(c), 64'(mon_b.ch));
                  check_eq("beat_data", m_udpdata_tdata[64*c +: 64], mon_b.data);
                  check_eq("beat_keep", 64'(m_udpdata_tkeep[8*c +: 8]), 64'(mon_b.keep));
                  check_eq("beat_last", 64'(m_udpdata_tlast[c]), 64'(mon_b.last));
               end
            end
         end
      end
   end

   // Called at posedge+1 with the block idle; returns at the following negedge.
   task automatic send_hdr(input logic [15:0] tdest, input logic [63:0] hdr, input int ch);
      bit ok;
      logic [NUM_PORTS-1:0] m;
      if (ch >= 0) hdr_sb.push_back('{ch, hdr});
      cur_ch          = ch;
      s_udphdr_tdata  = hdr;
      s_udphdr_tdest  = tdest;
      s_udphdr_tvalid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < TMO && !ok; k++) begin
         @(negedge clk);
         if (k == 0) check_eq("hdr_accept_first_cycle", 64'(s_udphdr_tready), 64'd1);
         ok = s_udphdr_tready;
      end
      if (!ok) check_eq("hdr_accept_timeout", 64'(s_udphdr_tready), 64'd1);
      @(posedge clk);
      #1;
      hdr_acc_cyc     = cyc;
      s_udphdr_tvalid = 1'b0;
      s_udphdr_tdest  = '0;
      s_udphdr_tdata  = '0;
      @(negedge clk);
      m = (ch >= 0) ? (NUM_PORTS'(1) << ch) : '0;
      check_eq("hdr_tvalid_next_cycle", 64'(m_udphdr_tvalid), 64'(m));
   endtask

   // Called at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input int ch);
      bit ok;
      if (ch >= 0) beat_sb.push_back('{ch, d, k, l});
      s_udpdata_tdata  = d;
      s_udpdata_tkeep  = k;
      s_udpdata_tlast  = l;
      s_udpdata_tvalid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < TMO && !ok; n++) begin
         @(negedge clk);
         if (ch < 0 && n == 0) check_eq("drop_tready", 64'(s_udpdata_tready), 64'd1);
         ok = s_udpdata_tready;
      end
      if (!ok) check_eq("beat_accept_timeout", 64'(s_udpdata_tready), 64'd1);
      @(posedge clk);
      #1;
      if (l) last_acc_cyc = cyc;
      s_udpdata_tvalid = 1'b0;
      s_udpdata_tdata  = '0;
      s_udpdata_tkeep  = '0;
      s_udpdata_tlast  = 1'b0;
   endtask

   task automatic send_beats(input int n, input logic [63:0] base, input int ch);
      @(posedge clk);
      #1;
      for (int i = 0; i < n; i++)
         send_beat(base + 64'(i), (i == n - 1) ? 8'h3F : 8'hFF, i == n - 1, ch);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      s_udphdr_tdata = '0;  s_udphdr_tdest = '0;  s_udphdr_tvalid = 1'b0;
      s_udpdata_tdata = '0; s_udpdata_tkeep = '0; s_udpdata_tlast = 1'b0;
      s_udpdata_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_hdr_tready", 64'(s_udphdr_tready), 64'd0);
      check_eq("rst_data_tready", 64'(s_udpdata_tready), 64'd0);
      check_eq("rst_m_hdr_tvalid", 64'(m_udphdr_tvalid), 64'd0);
      check_eq("rst_m_data_tvalid", 64'(m_udpdata_tvalid), 64'd0);
      check_eq("rst_drop_count", 64'(drop_count), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Routing to channel 2
      send_hdr(16'd21602, mk_hdr(32'hC0A8_010A, 16'd5000, 16'd24), 2);
      send_beats(3, 64'h0000_1111_0000_0100, 2);

      // Unmatched port is swallowed and counted
      check_eq("drop_count_before", 64'(drop_count), 64'd0);
      send_hdr(16'd80, mk_hdr(32'h0A00_0001, 16'd1234, 16'd40), -1);
      send_beats(5, 64'hDEAD_0000_0000_0000, -1);
      check_eq("drop_count_after", 64'(drop_count), 64'd1);

      // Backpressure on channel 0
      bp_en = 1'b1;
      send_hdr(16'd21600, mk_hdr(32'h0A00_0002, 16'd7000, 16'd32), 0);
      send_beats(4, 64'hBEEF_0000_0000_0010, 0);
      bp_en = 1'b0;

      // Back-to-back single-beat packets
      send_hdr(16'd21600, mk_hdr(32'h0A00_0003, 16'd7001, 16'd8), 0);
      send_beats(1, 64'h0000_0000_0000_0A0A, 0);
      send_hdr(16'd21603, mk_hdr(32'h0A00_0004, 16'd7002, 16'd8), 3);
      check_eq("b2b_hdr_gap", 64'(hdr_acc_cyc - last_acc_cyc), 64'd1);
      send_beats(1, 64'h0000_0000_0000_0B0B, 3);

      // Reset in the middle of a payload
      send_hdr(16'd21600, mk_hdr(32'h0A00_0005, 16'd7003, 16'd32), 0);
      @(posedge clk);
      #1;
      send_beat(64'h0000_0000_0000_00A0, 8'hFF, 1'b0, 0);
      send_beat(64'h0000_0000_0000_00A1, 8'hF0, 1'b0, 0);
      rst = 1'b1;
      s_udpdata_tdata  = 64'h0000_0000_0000_00A2;
      s_udpdata_tvalid = 1'b1;
      @(negedge clk);
      check_eq("midrst_m_data_tvalid", 64'(m_udpdata_tvalid), 64'd0);
      check_eq("midrst_data_tready", 64'(s_udpdata_tready), 64'd0);
      check_eq("midrst_hdr_tready", 64'(s_udphdr_tready), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("midrst_drop_count", 64'(drop_count), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      s_udpdata_tvalid = 1'b0;
      s_udpdata_tdata  = '0;
      cur_ch = -1;
      @(negedge clk);
      check_eq("postrst_m_hdr_tvalid", 64'(m_udphdr_tvalid), 64'd0);
      check_eq("postrst_m_data_tvalid", 64'(m_udpdata_tvalid), 64'd0);
      check_eq("postrst_m_hdr_tdata0", m_udphdr_tdata[63:0], 64'd0);
      check_eq("postrst_m_data_tdata0", m_udpdata_tdata[63:0], 64'd0);
      check_eq("postrst_data_tready", 64'(s_udpdata_tready), 64'd0);
      check_eq("postrst_drop_count", 64'(drop_count), 64'd0);
      @(posedge clk);
      #1;
      send_hdr(16'd21601, mk_hdr(32'h0A00_0006, 16'd7004, 16'd16), 1);
      send_beats(2, 64'h0000_2222_0000_0000, 1);

      // Saturation of the drop counter
      force dut.drop_cnt_q = 32'hFFFF_FFFE;
      repeat (2) @(posedge clk);
      #1;
      release dut.drop_cnt_q;
      @(negedge clk);
      check_eq("sat_preload", 64'(drop_count), 64'hFFFF_FFFE);
      @(posedge clk);
      #1;
      send_hdr(16'd80, mk_hdr(32'h0A00_0007, 16'd1, 16'd8), -1);
      send_beats(1, 64'h0000_0000_0000_0C00, -1);
      check_eq("sat_drop1", 64'(drop_count), 64'hFFFF_FFFF);
      send_hdr(16'd81, mk_hdr(32'h0A00_0008, 16'd2, 16'd16), -1);
      send_beats(2, 64'h0000_0000_0000_0C10, -1);
      check_eq("sat_drop2", 64'(drop_count), 64'hFFFF_FFFF);
      send_hdr(16'd21604, mk_hdr(32'h0A00_0009, 16'd3, 16'd8), -1);
      send_beats(1, 64'h0000_0000_0000_0C20, -1);
      check_eq("sat_drop3", 64'(drop_count), 64'hFFFF_FFFF);

      repeat (4) @(posedge clk);
      @(negedge clk);
      check_eq("hdr_sb_drained", 64'(hdr_sb.size()), 64'd0);
      check_eq("beat_sb_drained", 64'(beat_sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
